reg_write_arbiter: RTL and testbench

Two-requester write arbiter and strobe sequencer for the shared 4-bit register pair (A and B) in the part-2 datapath. The block accepts write requests from two sources (e.g. input switches and ALU result) and grants one at a time. It drives a single shared data bus to both registers and generates active-low latch strobes that the 4-bit registers sample on the rising clock edge. It returns a one-cycle acknowledge to the winning requester.

---
 rtl/reg_write_arbiter_if.sv | 39 +++
 rtl/reg_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter_if
// Bundle of request/acknowledge and register-side signals for the register
// pair write arbiter.
//   req0/data0/dest0/ack0 : requester 0 handshake (dest 0 = reg A, 1 = reg B)
//   req1/data1/dest1/ack1 : requester 1 handshake
//   bus_data              : shared data bus to registers A and B
//   latch_a_n, latch_b_n  : active-low load strobes
//   busy                  : arbiter is in a transaction
// Modports: master = requester/register side, slave = arbiter.
// ----------------------------------------------------------------------------
interface reg_write_arbiter_if #(
   parameter int unsigned DATA_W = 4
) ();

   logic              req0;
   logic [DATA_W-1:0] data0;
   logic              dest0;
   logic              ack0;
   logic              req1;
   logic [DATA_W-1:0] data1;
   logic              dest1;
   logic              ack1;
   logic [DATA_W-1:0] bus_data;
   logic              latch_a_n;
   logic              latch_b_n;
   logic              busy;

   modport master (
      output req0, data0, dest0, req1, data1, dest1,
      input  ack0, ack1, bus_data, latch_a_n, latch_b_n, busy
   );

   modport slave (
      input  req0, data0, dest0, req1, data1, dest1,
      output ack0, ack1, bus_data, latch_a_n, latch_b_n, busy
   );

endinterface

// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
// Two-requester write arbiter and strobe sequencer for the 4-bit register
// pair A/B. Grants one request at a time, drives the shared data bus, pulses
// the target's active-low latch strobe for LATCH_CYCLES cycles, then returns
// a one-cycle ack to the winner.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus_if  : reg_write_arbiter_if.slave (requests, acks, bus, strobes, busy)
// Parameters:
//   DATA_W        : data / bus width
//   LATCH_CYCLES  : strobe low time in cycles, 1..15
// Build option:
//   REG_WRITE_ARB_ROUND_ROBIN_EN defined   -> round-robin on contention
//   REG_WRITE_ARB_ROUND_ROBIN_EN undefined -> requester 0 fixed priority
// All outputs are registered.
// ----------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned LATCH_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_write_arbiter_if.slave    bus_if
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_ACK    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] bus_data_q, bus_data_d;
   logic              target_q, target_d;
   logic              grant_q, grant_d;
   logic              latch_a_n_q, latch_a_n_d;
   logic              latch_b_n_q, latch_b_n_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              any_req_c;
   logic              win_c;

   assign any_req_c = bus_if.req0 | bus_if.req1;

`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   // Contention goes to the requester not granted last time.
   always_comb begin
      win_c        = bus_if.req1;
      last_grant_d = last_grant_q;
      if (bus_if.req0 && bus_if.req1) begin
         win_c = ~last_grant_q;
      end
      if ((state_q == S_IDLE) && any_req_c) begin
         last_grant_d = win_c;
      end
   end

   // Pointer resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   // Fixed priority: requester 1 wins only when requester 0 is idle.
   always_comb begin
      win_c = ~bus_if.req0 & bus_if.req1;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, strobe counter and grant-time capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bus_data_d = bus_data_q;
      target_d   = target_q;
      grant_d    = grant_q;
      case (state_q)
         S_IDLE: begin
            if (any_req_c) begin
               state_d    = S_SETUP;
               bus_data_d = win_c ? bus_if.data1 : bus_if.data0;
               target_d   = win_c ? bus_if.dest1 : bus_if.dest0;
               grant_d    = win_c;
            end
         end
         S_SETUP: begin
            state_d = S_STROBE;
            cnt_d   = CNT_W'(LATCH_CYCLES);
         end
         S_STROBE: begin
            cnt_d = cnt_q - CNT_W'(1);
            // <= also guards a counter that somehow reads zero.
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      latch_a_n_d = 1'b1;
      latch_b_n_d = 1'b1;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      busy_d      = (state_d != S_IDLE);
      if (state_d == S_STROBE) begin
         if (target_d) begin
            latch_b_n_d = 1'b0;
         end else begin
            latch_a_n_d = 1'b0;
         end
      end
      if (state_d == S_ACK) begin
         ack0_d = ~grant_d;
         ack1_d = grant_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         bus_data_q  <= '0;
         target_q    <= 1'b0;
         grant_q     <= 1'b0;
         latch_a_n_q <= 1'b1;
         latch_b_n_q <= 1'b1;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bus_data_q  <= bus_data_d;
         target_q    <= target_d;
         grant_q     <= grant_d;
         latch_a_n_q <= latch_a_n_d;
         latch_b_n_q <= latch_b_n_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         busy_q      <= busy_d;
      end
   end

   assign bus_if.bus_data  = bus_data_q;
   assign bus_if.latch_a_n = latch_a_n_q;
   assign bus_if.latch_b_n = latch_b_n_q;
   assign bus_if.ack0      = ack0_q;
   assign bus_if.ack1      = ack1_q;
   assign bus_if.busy      = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed and random stimulus for reg_write_arbiter (LATCH_CYCLES = 3),
// checked each cycle against a transaction-level model: a grant records the
// edge count since grant, and every output follows from that age.
// ----------------------------------------------------------------------------
module tb_reg_write_arbiter;

   localparam int unsigned DW  = 4;
   localparam int unsigned LAT = 3;
   localparam int          TX  = int'(LAT) + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;
   bit   rand_en = 1'b0;

   reg_write_arbiter_if #(.DATA_W(DW)) bif ();

   reg_write_arbiter #(
      .DATA_W       (DW),
      .LATCH_CYCLES (LAT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bif.slave)
   );

   always #5 clk = ~clk;

   // Model: active transaction, edges since grant, captured payload.
   bit          m_active;
   int          m_age;
   bit          m_gid;
   bit          m_dest;
   bit          m_last;
   logic [DW-1:0] m_bus;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_gid    = 1'b0;
      m_dest   = 1'b0;
      m_last   = 1'b1;
      m_bus    = '0;
   endtask

   task automatic model_edge();
      bit w;
      if (!rst_n) begin
         model_reset();
      end else if (m_active) begin
         m_age++;
         if (m_age == TX) m_active = 1'b0;
      end else if (bif.req0 || bif.req1) begin
         w = bif.req1 && !bif.req0;
         if (bif.req0 && bif.req1) begin
`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
            w = !m_last;
`else
            w = 1'b0;
`endif
         end
         m_active = 1'b1;
         m_age    = 1;
         m_gid    = w;
         m_dest   = w ? bif.dest1 : bif.dest0;
         m_bus    = w ? bif.data1 : bif.data0;
         m_last   = w;
      end
   endtask

   task automatic check_all(input string ph);
      bit strobe;
      bit ackc;
      strobe = m_active && (m_age >= 2) && (m_age <= int'(LAT) + 1);
      ackc   = m_active && (m_age == int'(LAT) + 2);
      chk({ph, ".bus"},   8'(bif.bus_data),  8'(m_bus));
      chk({ph, ".la_n"},  8'(bif.latch_a_n), 8'(!(strobe && !m_dest)));
      chk({ph, ".lb_n"},  8'(bif.latch_b_n), 8'(!(strobe && m_dest)));
      chk({ph, ".ack0"},  8'(bif.ack0),      8'(ackc && !m_gid));
      chk({ph, ".ack1"},  8'(bif.ack1),      8'(ackc && m_gid));
      chk({ph, ".busy"},  8'(bif.busy),      8'(m_active));
   endtask

   // One clock: advance model, sample away from the edge, react as requesters.
   task automatic tick(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
      if (bif.req0 && bif.ack0) bif.req0 = 1'b0;
      else if (rand_en && !bif.req0 && ($urandom_range(0, 2) == 0)) begin
         bif.req0  = 1'b1;
         bif.data0 = 4'($urandom);
         bif.dest0 = 1'($urandom);
      end else if (rand_en && ($urandom_range(0, 3) == 0)) begin
         bif.data0 = 4'($urandom);
         bif.dest0 = 1'($urandom);
      end
      if (bif.req1 && bif.ack1) bif.req1 = 1'b0;
      else if (rand_en && !bif.req1 && ($urandom_range(0, 2) == 0)) begin
         bif.req1  = 1'b1;
         bif.data1 = 4'($urandom);
         bif.dest1 = 1'($urandom);
      end else if (rand_en && ($urandom_range(0, 3) == 0)) begin
         bif.data1 = 4'($urandom);
         bif.dest1 = 1'($urandom);
      end
   endtask

   task automatic ticks(input string ph, input int n);
      repeat (n) tick(ph);
   endtask

   initial begin
      model_reset();
      bif.req0  = 1'b0;
      bif.data0 = '0;
      bif.dest0 = 1'b0;
      bif.req1  = 1'b0;
      bif.data1 = '0;
      bif.dest1 = 1'b0;

      // Reset values while held in reset.
      #12;
      check_all("reset");
      rst_n = 1'b1;
      ticks("idle", 2);

      // Contention straight after reset, both held until acked.
      bif.req0 = 1'b1; bif.data0 = 4'h3; bif.dest0 = 1'b1;
      bif.req1 = 1'b1; bif.data1 = 4'h5; bif.dest1 = 1'b0;
      ticks("cont1", 2 * TX + 2);

      // Repeated contention.
      bif.req0 = 1'b1; bif.data0 = 4'h3; bif.dest0 = 1'b1;
      bif.req1 = 1'b1; bif.data1 = 4'h5; bif.dest1 = 1'b0;
      ticks("cont2", 2 * TX + 2);

      // Single write to A; data changes right after grant.
      bif.req0 = 1'b1; bif.data0 = 4'hA; bif.dest0 = 1'b0;
      tick("single");
      bif.data0 = 4'hF;
      ticks("single", TX + 1);
      chk("single.hold", 8'(bif.bus_data), 8'h0A);

      // Requester 1 arrives while requester 0 is strobing.
      bif.req0 = 1'b1; bif.data0 = 4'h6; bif.dest0 = 1'b1;
      tick("late");
      tick("late");
      bif.req1 = 1'b1; bif.data1 = 4'h9; bif.dest1 = 1'b0;
      ticks("late", 2 * TX + 2);

      // Async reset during STROBE.
      bif.req0 = 1'b1; bif.data0 = 4'hC; bif.dest0 = 1'b1;
      tick("prerst");
      tick("prerst");
      chk("prerst.lb_low", 8'(bif.latch_b_n), 8'h00);
      #2;
      rst_n    = 1'b0;
      bif.req0 = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      ticks("in_rst", 2);
      rst_n = 1'b1;
      ticks("post_rst", 3);
      chk("post_rst.busy", 8'(bif.busy), 8'h00);

      // Random traffic.
      rand_en = 1'b1;
      ticks("rand", 600);
      rand_en  = 1'b0;
      bif.req0 = 1'b0;
      bif.req1 = 1'b0;
      ticks("drain", 2 * TX + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
